ram2_arbiter: RTL

Shares the single off-chip RAM2 SRAM between the instruction-fetch port (IF stage) and the data-memory port (MEM stage) of the 16-bit CPU. The block runs the asynchronous SRAM's read and write strobe sequences and gives each access a one-cycle acknowledge. Data accesses have fixed priority over fetches. The pipeline stalls IF and/or MEM until the matching ack arrives.

---
 rtl/ram2_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ram2_arbiter.sv
// Arbitrates the single RAM2 SRAM between instruction fetch and data memory,
// generating the asynchronous SRAM strobe sequences with registered outputs.
module ram2_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_ack,
    input  logic        dm_read,
    input  logic        dm_write,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic [15:0] dm_rdata,
    output logic        dm_ack,
    output logic        busy,
    output logic [17:0] ram2_addr,
    output logic [15:0] ram2_dout,
    input  logic [15:0] ram2_din,
    output logic        ram2_drive,
    output logic        ram2_en_n,
    output logic        ram2_oe_n,
    output logic        ram2_we_n
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RD       = 3'd1;
    localparam logic [2:0] S_WR_SETUP = 3'd2;
    localparam logic [2:0] S_WR_PULSE = 3'd3;
    localparam logic [2:0] S_WR_HOLD  = 3'd4;

    localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);

    logic [2:0]  r_state;
    logic [2:0]  r_cnt;
    logic        r_owner_dm;
    logic [15:0] r_addr;
    logic [15:0] r_dout;
    logic [15:0] r_if_rdata;
    logic [15:0] r_dm_rdata;
    logic        r_if_ack;
    logic        r_dm_ack;
    logic        r_busy;
    logic        r_drive;
    logic        r_en_n;
    logic        r_oe_n;
    logic        r_we_n;
    logic        w_cnt_last;

    assign w_cnt_last = (r_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_owner_dm <= 1'b0;
            r_addr     <= '0;
            r_dout     <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
            r_if_ack   <= 1'b0;
            r_dm_ack   <= 1'b0;
            r_busy     <= 1'b0;
            r_drive    <= 1'b0;
            r_en_n     <= 1'b1;
            r_oe_n     <= 1'b1;
            r_we_n     <= 1'b1;
        end else begin
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Address/data only latch here, while en_n is high.
                    r_cnt <= '0;
                    if (dm_write) begin
                        r_addr     <= dm_addr;
                        r_dout     <= dm_wdata;
                        r_owner_dm <= 1'b1;
                        r_state    <= S_WR_SETUP;
                        r_en_n     <= 1'b0;
                        r_drive    <= 1'b1;
                        r_busy     <= 1'b1;
                    end else if (dm_read) begin
                        r_addr     <= dm_addr;
                        r_owner_dm <= 1'b1;
                        r_state    <= S_RD;
                        r_en_n     <= 1'b0;
                        r_oe_n     <= 1'b0;
                        r_busy     <= 1'b1;
                    end else if (if_req) begin
                        r_addr     <= if_addr;
                        r_owner_dm <= 1'b0;
                        r_state    <= S_RD;
                        r_en_n     <= 1'b0;
                        r_oe_n     <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_RD: begin
                    if (w_cnt_last) begin
                        if (r_owner_dm) begin
                            r_dm_rdata <= ram2_din;
                            r_dm_ack   <= 1'b1;
                        end else begin
                            r_if_rdata <= ram2_din;
                            r_if_ack   <= 1'b1;
                        end
                        r_en_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_WR_SETUP: begin
                    r_we_n  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_WR_PULSE;
                end
                S_WR_PULSE: begin
                    if (w_cnt_last) begin
                        r_we_n  <= 1'b1;
                        r_state <= S_WR_HOLD;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_WR_HOLD: begin
                    r_dm_ack <= 1'b1;
                    r_en_n   <= 1'b1;
                    r_drive  <= 1'b0;
                    r_busy   <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_en_n  <= 1'b1;
                    r_oe_n  <= 1'b1;
                    r_we_n  <= 1'b1;
                    r_drive <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign if_rdata   = r_if_rdata;
    assign if_ack     = r_if_ack;
    assign dm_rdata   = r_dm_rdata;
    assign dm_ack     = r_dm_ack;
    assign busy       = r_busy;
    assign ram2_addr  = {2'b00, r_addr};
    assign ram2_dout  = r_dout;
    assign ram2_drive = r_drive;
    assign ram2_en_n  = r_en_n;
    assign ram2_oe_n  = r_oe_n;
    assign ram2_we_n  = r_we_n;

endmodule
